// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: parity encodings, TX FSM states
// and the frame data width.
package uart_pkg;

    localparam int DATA_W = 8;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Mode 2'b11 is deliberately folded into "no parity".
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer for the UART transmitter: counts 0..divisor and pulses
// bit_tick on the terminal count; restart holds the count at zero.
module uart_baud_gen #(
    parameter int BAUD_W = 24
) (
    input  logic              uart_clk,
    input  logic              nrst,
    input  logic [BAUD_W-1:0] divisor,
    input  logic              restart,
    output logic              bit_tick
);

    logic [BAUD_W-1:0] cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge uart_clk) begin
        if (!nrst || restart) begin
            cnt <= '0;
        end else if (cnt == divisor) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + BAUD_W'(1);
        end
    end

    assign bit_tick = !restart && (cnt == divisor);

endmodule

// File: rtl/uart_tx_encoder.sv
// Byte-oriented UART transmitter: start, 8 data bits LSB-first, optional parity,
// 1 or 2 stop bits. Define UART_TX_FIFO_EN to replace the holding register with a FIFO.
module uart_tx_encoder #(
    parameter int DATA_W     = 8,
    parameter int BAUD_W     = 24,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              uart_clk,
    input  logic              nrst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic [1:0]        parity,
    input  logic              stop_sel,
    input  logic [BAUD_W-1:0] baudcontrol,
    output logic              uart_tx,
    output logic              busy,
    output logic              uart_rco
);

    import uart_pkg::*;

    tx_state_t         state, state_n;
    logic [2:0]        bit_idx, bit_idx_n;
    logic              stop_idx, stop_idx_n;
    logic [DATA_W-1:0] shift_q, shift_n;
    logic              par_bit_q, par_bit_n;
    logic              par_on_q, par_on_n;
    logic              stop2_q, stop2_n;
    logic [BAUD_W-1:0] baud_q, baud_n;
    logic              tx_q, tx_n;
    logic              load;
    logic              frame_end;
    logic              bit_tick;

    logic              push;
    logic              buf_has;
    logic              buf_full;
    logic [DATA_W-1:0] buf_data;

    // A pop (load) frees space in the same cycle, so a push may coincide with it.
    assign data_ready = !buf_full || load;
    assign push       = data_valid && data_ready;

`ifdef UART_TX_FIFO_EN
    if (1) begin : g_fifo
        localparam int AW = $clog2(FIFO_DEPTH);

        logic [DATA_W-1:0] mem [FIFO_DEPTH];
        logic [AW-1:0]     wr_ptr, rd_ptr;
        logic [AW:0]       count;

        // NOTE: the storage array carries no reset; only pointers and count do,
        // which is enough to flush it and keeps the array a plain RAM.
        always_ff @(posedge uart_clk) begin
            if (push) begin
                mem[wr_ptr] <= data_in;
            end
        end

        always_ff @(posedge uart_clk) begin
            if (!nrst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (load) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({push, load})
                    2'b10:   count <= count + (AW+1)'(1);
                    2'b01:   count <= count - (AW+1)'(1);
                    default: count <= count;
                endcase
            end
        end

        assign buf_full = (count == (AW+1)'(FIFO_DEPTH));
        assign buf_has  = (count != '0);
        assign buf_data = mem[rd_ptr];
    end
`else
    if (1) begin : g_hold
        logic              hold_full;
        logic [DATA_W-1:0] hold_q;

        always_ff @(posedge uart_clk) begin
            if (!nrst) begin
                hold_full <= 1'b0;
                hold_q    <= '0;
            end else if (push) begin
                hold_full <= 1'b1;
                hold_q    <= data_in;
            end else if (load) begin
                hold_full <= 1'b0;
            end
        end

        assign buf_full = hold_full;
        assign buf_has  = hold_full;
        assign buf_data = hold_q;
    end
`endif

    uart_baud_gen #(
        .BAUD_W (BAUD_W)
    ) u_baud_gen (
        .uart_clk (uart_clk),
        .nrst     (nrst),
        .divisor  (baud_q),
        .restart  (state == IDLE),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge uart_clk) begin
        if (!nrst) begin
            state     <= IDLE;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            shift_q   <= '0;
            par_bit_q <= 1'b0;
            par_on_q  <= 1'b0;
            stop2_q   <= 1'b0;
            baud_q    <= '0;
            tx_q      <= 1'b1;
        end else begin
            state     <= state_n;
            bit_idx   <= bit_idx_n;
            stop_idx  <= stop_idx_n;
            shift_q   <= shift_n;
            par_bit_q <= par_bit_n;
            par_on_q  <= par_on_n;
            stop2_q   <= stop2_n;
            baud_q    <= baud_n;
            tx_q      <= tx_n;
        end
    end

    // The line level is registered: tx_n is the level for the state being entered.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_n    = state;
        bit_idx_n  = bit_idx;
        stop_idx_n = stop_idx;
        shift_n    = shift_q;
        par_bit_n  = par_bit_q;
        par_on_n   = par_on_q;
        stop2_n    = stop2_q;
        baud_n     = baud_q;
        tx_n       = tx_q;
        load       = 1'b0;
        frame_end  = 1'b0;

        case (state)
            IDLE: begin
                if (buf_has) begin
                    load    = 1'b1;
                    state_n = START;
                    tx_n    = 1'b0;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_n   = DATA;
                    bit_idx_n = '0;
                    tx_n      = shift_q[0];
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_idx == 3'(DATA_W - 1)) begin
                        if (par_on_q) begin
                            state_n = PARITY;
                            tx_n    = par_bit_q;
                        end else begin
                            state_n    = STOP;
                            stop_idx_n = 1'b0;
                            tx_n       = 1'b1;
                        end
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        shift_n   = {1'b0, shift_q[DATA_W-1:1]};
                        tx_n      = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    state_n    = STOP;
                    stop_idx_n = 1'b0;
                    tx_n       = 1'b1;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    if (stop2_q && !stop_idx) begin
                        stop_idx_n = 1'b1;
                    end else begin
                        frame_end = 1'b1;
                        if (buf_has) begin
                            load    = 1'b1;
                            state_n = START;
                            tx_n    = 1'b0;
                        end else begin
                            state_n = IDLE;
                            tx_n    = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase

        // Frame configuration is frozen at START entry.
        if (load) begin
            shift_n   = buf_data;
            par_bit_n = (^buf_data) ^ (parity == PAR_ODD);
            par_on_n  = parity_enabled(parity);
            stop2_n   = stop_sel;
            baud_n    = baudcontrol;
        end
    end

    assign uart_tx  = tx_q;
    assign busy     = (state != IDLE) || buf_has;
    assign uart_rco = frame_end && nrst;

endmodule

// File: tb/tb_uart_tx_encoder.sv
// Scoreboard bench for uart_tx_encoder: stimulus queues expected frames, a monitor
// decodes uart_tx cycle by cycle and compares against them.
module tb_uart_tx_encoder;

    import uart_pkg::*;

    localparam int BAUD_W = 24;

    logic              uart_clk = 1'b0;
    logic              nrst = 1'b0;
    logic [7:0]        data_in = '0;
    logic              data_valid = 1'b0;
    logic              data_ready;
    logic [1:0]        parity = PAR_NONE;
    logic              stop_sel = 1'b0;
    logic [BAUD_W-1:0] baudcontrol = '0;
    logic              uart_tx;
    logic              busy;
    logic              uart_rco;

    typedef struct {
        logic [7:0] data;
        logic [1:0] par;
        logic       stop2;
        int         bc;
        int         start_cyc;
        bit         no_gap;
    } exp_t;

    exp_t sb[$];

    int n_checks  = 0;
    int n_pass    = 0;
    int cyc       = 0;
    int rco_count = 0;
    bit mon_en    = 1'b1;

    uart_tx_encoder #(
        .DATA_W     (8),
        .BAUD_W     (BAUD_W),
        .FIFO_DEPTH (16)
    ) dut (
        .uart_clk    (uart_clk),
        .nrst        (nrst),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .parity      (parity),
        .stop_sel    (stop_sel),
        .baudcontrol (baudcontrol),
        .uart_tx     (uart_tx),
        .busy        (busy),
        .uart_rco    (uart_rco)
    );

    always #5 uart_clk = ~uart_clk;

    initial begin : cycle_counter
        forever begin
            @(posedge uart_clk);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic send(input logic [7:0] b, input logic [1:0] par, input logic st,
                        input int bc, input bit chk_start, input bit no_gap, input bit track);
        int   w;
        exp_t e;
        data_in     = b;
        parity      = par;
        stop_sel    = st;
        baudcontrol = BAUD_W'(bc);
        data_valid  = 1'b1;
        w = 0;
        while (data_ready !== 1'b1 && w < 2000) begin
            @(negedge uart_clk);
            w++;
        end
        if (data_ready !== 1'b1) begin
            check("accept_wait", {31'd0, data_ready}, 32'd1);
            data_valid = 1'b0;
            return;
        end
        if (track) begin
            e.data      = b;
            e.par       = par;
            e.stop2     = st;
            e.bc        = bc;
            e.start_cyc = chk_start ? cyc + 2 : -1;
            e.no_gap    = no_gap;
            sb.push_back(e);
        end
        @(negedge uart_clk);
    endtask

    task automatic wait_idle(input int limit);
        int w;
        data_valid = 1'b0;
        w = 0;
        while ((busy !== 1'b0 || sb.size() != 0) && w < limit) begin
            @(negedge uart_clk);
            w++;
        end
        @(negedge uart_clk);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_line", {31'd0, uart_tx}, 32'd1);
        check("idle_ready", {31'd0, data_ready}, 32'd1);
    endtask

    initial begin : monitor
        exp_t       cur;
        bit         in_frame;
        bit         bit_ok;
        bit         rco_ok;
        bit         last;
        int         pos;
        int         sub;
        int         nbits;
        int         last_end;
        logic       lv [12];
        logic [7:0] rx;
        in_frame = 1'b0;
        last_end = -100;
        pos = 0;
        sub = 0;
        nbits = 0;
        bit_ok = 1'b1;
        rco_ok = 1'b1;
        rx = '0;
        forever begin
            @(negedge uart_clk);
            if (uart_rco === 1'b1) rco_count++;
            if (!nrst || !mon_en) begin
                in_frame = 1'b0;
            end else begin
                if (!in_frame && uart_tx === 1'b0) begin
                    check("frame_expected", {31'd0, sb.size() > 0}, 32'd1);
                    if (sb.size() > 0) begin
                        cur = sb.pop_front();
                        lv[0] = 1'b0;
                        for (int i = 0; i < 8; i++) lv[i+1] = cur.data[i];
                        nbits = 9;
                        if (cur.par == PAR_EVEN || cur.par == PAR_ODD) begin
                            lv[nbits] = (cur.par == PAR_ODD) ? ~(^cur.data) : ^cur.data;
                            nbits++;
                        end
                        lv[nbits] = 1'b1;
                        nbits++;
                        if (cur.stop2) begin
                            lv[nbits] = 1'b1;
                            nbits++;
                        end
                        if (cur.start_cyc >= 0) check("start_cycle", cyc, cur.start_cyc);
                        if (cur.no_gap) check("no_gap_start", cyc, last_end + 1);
                        in_frame = 1'b1;
                        pos = 0;
                        sub = 0;
                        bit_ok = 1'b1;
                        rco_ok = 1'b1;
                        rx = '0;
                    end
                end else if (!in_frame && uart_rco === 1'b1) begin
                    check("rco_outside_frame", {31'd0, uart_rco}, 32'd0);
                end
                if (in_frame) begin
                    if (uart_tx !== lv[pos]) bit_ok = 1'b0;
                    last = (pos == nbits - 1) && (sub == cur.bc);
                    if (uart_rco !== last) rco_ok = 1'b0;
                    if (pos >= 1 && pos <= 8 && sub == cur.bc / 2) rx[pos-1] = uart_tx;
                    if (sub == cur.bc) begin
                        check($sformatf("frame_%02h_bit%0d", cur.data, pos), {31'd0, bit_ok}, 32'd1);
                        bit_ok = 1'b1;
                        sub = 0;
                        pos++;
                        if (pos == nbits) begin
                            check("rco_timing", {31'd0, rco_ok}, 32'd1);
                            check("decoded_byte", {24'd0, rx}, {24'd0, cur.data});
                            last_end = cyc;
                            in_frame = 1'b0;
                        end
                    end else begin
                        sub++;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int w;
        int rco_before;
        bit low_seen;

        nrst = 1'b0;
        repeat (3) @(negedge uart_clk);
        check("reset_tx", {31'd0, uart_tx}, 32'd1);
        check("reset_ready", {31'd0, data_ready}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_rco", {31'd0, uart_rco}, 32'd0);
        nrst = 1'b1;
        @(negedge uart_clk);

        // 0x55, 4 cycles per bit, no parity, one stop: 40-cycle frame.
        send(8'h55, PAR_NONE, 1'b0, 3, 1'b1, 1'b0, 1'b1);
        wait_idle(200);

        // 0x07 has three ones: even parity bit 1, odd parity bit 0; mode 11 has none.
        send(8'h07, PAR_EVEN, 1'b0, 1, 1'b1, 1'b0, 1'b1);
        wait_idle(200);
        send(8'h07, PAR_ODD, 1'b0, 1, 1'b1, 1'b0, 1'b1);
        wait_idle(200);
        send(8'h07, 2'b11, 1'b0, 1, 1'b1, 1'b0, 1'b1);
        wait_idle(200);

        // One cycle per bit, two stop bits: 11-cycle frame.
        send(8'hFF, PAR_NONE, 1'b1, 0, 1'b1, 1'b0, 1'b1);
        wait_idle(200);

        // Back-to-back with data_valid held high.
        send(8'hA5, PAR_NONE, 1'b0, 2, 1'b1, 1'b0, 1'b1);
        send(8'h3C, PAR_NONE, 1'b0, 2, 1'b0, 1'b1, 1'b1);
        wait_idle(400);

        // Reset during data bit 4 of 0xC3 with a second byte buffered.
        mon_en = 1'b0;
        send(8'hC3, PAR_NONE, 1'b0, 3, 1'b0, 1'b0, 1'b0);
        send(8'h99, PAR_NONE, 1'b0, 3, 1'b0, 1'b0, 1'b0);
        data_valid = 1'b0;
        rco_before = rco_count;
        w = 0;
        while (uart_tx !== 1'b0 && w < 50) begin
            @(negedge uart_clk);
            w++;
        end
        repeat (21) @(negedge uart_clk);
        check("bit4_before_reset", {31'd0, uart_tx}, 32'd0);
        check("busy_before_reset", {31'd0, busy}, 32'd1);
        nrst = 1'b0;
        @(negedge uart_clk);
        check("midframe_reset_tx", {31'd0, uart_tx}, 32'd1);
        check("midframe_reset_busy", {31'd0, busy}, 32'd0);
        check("midframe_reset_ready", {31'd0, data_ready}, 32'd1);
        @(negedge uart_clk);
        nrst = 1'b1;
        low_seen = 1'b0;
        repeat (60) begin
            @(negedge uart_clk);
            if (uart_tx !== 1'b1) low_seen = 1'b1;
        end
        check("line_quiet_after_reset", {31'd0, low_seen}, 32'd0);
        check("no_rco_on_reset", rco_count, rco_before);
        mon_en = 1'b1;

`ifdef UART_TX_FIFO_EN
        // A 40-cycle frame blocks the line while 16 bytes fill the FIFO.
        send(8'hEE, PAR_NONE, 1'b0, 3, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            send(8'(i), PAR_NONE, 1'b0, 3, 1'b0, 1'b1, 1'b1);
        end
        check("fifo_full_ready", {31'd0, data_ready}, 32'd0);
        send(8'h10, PAR_NONE, 1'b0, 3, 1'b0, 1'b1, 1'b1);
        wait_idle(2000);
`endif

        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_encoder.md
Name: uart_tx_encoder

Overview:
Byte-oriented UART transmitter (serial encoder). It takes bytes through a valid/ready handshake and serialises each one onto uart_tx as start, 8 data bits LSB-first, optional parity, then 1 or 2 stop bits. It drives the RX pin of the core's UART peripheral, both in bench stimulus and in loopback. It is the transmit counterpart of the existing UART TX-line sampler in the top-level bench.

Parameters:
DATA_W, 8, data bits per frame; fixed at 8, other values unsupported.
BAUD_W, 24, width of the baudcontrol divisor.
FIFO_DEPTH, 16, TX buffer depth; used only when UART_TX_FIFO_EN is defined; power of 2.

Ports:
uart_clk  input  1  block clock.
nrst  input  1  reset.
data_in  input  8  byte to transmit.
data_valid  input  1  data_in is valid.
data_ready  output  1  block can accept a byte this cycle.
parity  input  2  00 none, 01 even, 10 odd, 11 treated as none.
stop_sel  input  1  0 = one stop bit, 1 = two stop bits.
baudcontrol  input  BAUD_W  bit period minus 1, in uart_clk cycles.
uart_tx  output  1  serial line, idle high.
busy  output  1  a frame is in progress or a byte is buffered.
uart_rco  output  1  one-cycle pulse on the last cycle of each frame's final stop bit.

Behaviour:
- Clocking/reset: reset nrst, synchronous, active-low; clock uart_clk. All state updates on posedge uart_clk.
- Reset values: uart_tx=1, data_ready=1, busy=0, uart_rco=0, state=IDLE, holding register empty, baud counter=0.
- Handshake: a byte is accepted when data_valid && data_ready at a posedge.
  - Non-FIFO build: a single holding register; data_ready = holding register empty.
  - A byte may be accepted in the same cycle the previous byte moves from the holding register into the shift register.
- Configuration latch: parity, stop_sel and baudcontrol are captured when a frame enters START. Changes during a frame have no effect until the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when the holding register is full. uart_tx goes low on the edge after the accept edge, so first start-bit cycle = accept edge + 1.
  - START: uart_tx=0 for baudcontrol+1 cycles, then -> DATA.
  - DATA: bits sent LSB-first, each held baudcontrol+1 cycles; a 3-bit index counts 0..7. After bit 7 -> PARITY if parity is 01 or 10, otherwise -> STOP.
  - PARITY: even mode sends XOR of the data bits; odd mode sends its inverse; held one bit period, then -> STOP.
  - STOP: uart_tx=1 for 1 or 2 bit periods. On the final cycle uart_rco=1. Then -> START if the holding register is full (no idle gap between frames), else -> IDLE.
- Baud counter: counts 0..baudcontrol, terminal count advances the bit. baudcontrol=0 gives 1 cycle per bit; maximum is 2^24 cycles per bit.
- Frame length (cycles) = (baudcontrol+1) × (10 + parity_on + stop_sel).
- busy = (state != IDLE) || holding register full.
- Reset mid-frame: uart_tx returns to 1 on the next edge, buffered data is discarded, and no uart_rco pulse is issued.
- data_valid while data_ready=0: ignored, never latched. The source must hold the byte.

Optional Feature:
UART_TX_FIFO_EN
- Defined: the holding register is replaced by a FIFO_DEPTH-entry FIFO.
  - data_ready = !full.
  - busy includes !empty.
  - A simultaneous push and pop at full is allowed, because the pop frees a slot in the same cycle.
  - Reset flushes the FIFO.
- Undefined: a single holding register, so only one byte can be buffered.

Decomposition:
- Shared package uart_pkg: parity encoding constants (PAR_NONE, PAR_EVEN, PAR_ODD), FSM state enum for tx_state_t, and DATA_W.
- One sub-module, uart_baud_gen: takes the latched divisor and a restart input, and outputs a bit_tick pulse.
- The FIFO, when enabled, is an inline generate block and not a separate module.

Test Plan:
1. baudcontrol=3, parity=00, stop_sel=0, send 0x55 -> uart_tx = 0,1,0,1,0,1,0,1,0,1, each level held 4 cycles; uart_rco pulses on cycle 40 of the frame; line idles at 1 afterwards.
2. baudcontrol=1, parity=01, send 0x07 -> parity bit=1, frame is 22 cycles. Repeat with parity=10 -> parity bit=0.
3. stop_sel=1, baudcontrol=0, send 0xFF -> 11-cycle frame with 2 stop cycles; uart_rco on cycle 11.
4. Back-to-back 0xA5 then 0x3C with data_valid held high -> the second start bit immediately follows the first stop bit with no idle cycle; decoded bytes are 0xA5, 0x3C.
5. Assert nrst=0 during bit 4 of 0xC3 -> uart_tx=1, busy=0, data_ready=1 the next cycle; no uart_rco pulse.
6. With UART_TX_FIFO_EN: push 17 bytes 0x00..0x10 while the line is blocked by a frame in progress -> data_ready drops after 16 are accepted; all accepted bytes are emitted in order; the 17th is accepted once the first pop frees a slot.
